// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver for the core clock domain.
// The asynchronous rxd line is synchronised, each frame is sampled at its
// bit centres, and the received byte is held in a one-entry valid/ready
// output register. Framing errors and overruns are reported as one-cycle pulses.
module uart_rx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // The half-bit load lands the start-bit sample, and therefore every later
  // sample, near the centre of its bit.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic rxd_s;
  logic tick;

  assign rxd_s = sync2_q;
  assign tick  = (cnt_q == '0);

  // Two-flop synchroniser; reset to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  // State, timing and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Frame sequencing and the valid/ready handoff. A consume is applied first
  // so that a delivery in the same cycle overrides it, keeping rx_valid high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rxd_s) begin
          cnt_d   = HALF_LOAD;
          state_d = S_START;
        end
      end

      S_START: begin
        if (tick) begin
          if (!rxd_s) begin
            cnt_d   = FULL_LOAD;
            idx_d   = '0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DATA: begin
        if (tick) begin
          shift_d = {rxd_s, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_STOP: begin
        if (tick) begin
          if (rxd_s) begin
            if (!valid_q || rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_BREAK: begin
        if (rxd_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 10 clocks per bit.
// A reference model predicts the output register from frame start times,
// the fixed receive latency and the valid/ready handoff rules.
module tb_uart_rx;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int LAT    = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Rising edge count; just after edge P it reads P.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [7:0] b;
    logic       ferr;
  } evt_t;

  evt_t evq[$];
  evt_t mEvt;

  int   vectors     = 0;
  int   miscompares = 0;
  bit   randReady   = 1'b0;

  logic       mValid  = 1'b0;
  logic [7:0] mData   = 8'h00;
  logic       rdyPrev = 1'b0;
  logic       expFerr;
  logic       expOvr;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, actual, expected);
    end
  endtask

  // Reference model: after each edge, work out what the output register
  // should hold from the frame events due at that edge and the rx_ready
  // value that edge sampled, then compare against the DUT.
  always @(negedge clk) begin
    expFerr = 1'b0;
    expOvr  = 1'b0;
    if (reset) begin
      mValid = 1'b0;
      mData  = 8'h00;
      evq.delete();
      checkOutput("busyInReset", 8'(busy), 8'h00);
    end else if (evq.size() > 0 && evq[0].at == cyc) begin
      mEvt = evq.pop_front();
      if (mEvt.ferr) begin
        expFerr = 1'b1;
        if (mValid && rdyPrev) mValid = 1'b0;
      end else if (!mValid || rdyPrev) begin
        mData  = mEvt.b;
        mValid = 1'b1;
      end else begin
        expOvr = 1'b1;
      end
    end else if (mValid && rdyPrev) begin
      mValid = 1'b0;
    end
    checkOutput("rxValid",  8'(rx_valid),  8'(mValid));
    checkOutput("rxData",   rx_data,       mData);
    checkOutput("frameErr", 8'(frame_err), 8'(expFerr));
    checkOutput("overrun",  8'(overrun),   8'(expOvr));
    rdyPrev = rx_ready;
  end

  task automatic waitCycle();
    @(posedge clk);
    #1;
    if (randReady) rx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) waitCycle();
  endtask

  // Sends one frame starting now (just after an edge); rxd is left at the
  // stop-bit level. Optionally pulses rx_ready for exactly the stop-tick cycle.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input bit readyAtStopTick);
    int         startEdge;
    logic [9:0] bits;
    bits      = {stopBit, b, 1'b0};
    startEdge = cyc;
    evq.push_back('{at: startEdge + LAT + 1, b: b, ferr: !stopBit});
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      for (int k = 0; k < CPB; k++) begin
        waitCycle();
        if (readyAtStopTick) rx_ready = (cyc == startEdge + LAT);
      end
    end
  endtask

  int   g;
  int   gap;
  logic [7:0] rb;
  logic       rs;

  initial begin
    reset    = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    repeat (3) waitCycle();
    reset = 1'b0;
    repeat (2) waitCycle();
    checkOutput("busyAfterReset", 8'(busy), 8'h00);

    // Single frame with the consumer always ready.
    rx_ready = 1'b1;
    applyStimulus(8'h55, 1'b1, 1'b0);
    checkOutput("busyAfterFrame", 8'(busy), 8'h00);
    idle(5);

    // Back-to-back frames with no consumer: second one overruns.
    rx_ready = 1'b0;
    applyStimulus(8'hA3, 1'b1, 1'b0);
    applyStimulus(8'h0F, 1'b1, 1'b0);
    checkOutput("heldByte", rx_data, 8'hA3);
    rx_ready = 1'b1;
    idle(5);

    // Stop bit low followed by a held-low line.
    applyStimulus(8'h3C, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (30) waitCycle();
    checkOutput("busyInBreak", 8'(busy), 8'h01);
    rxd = 1'b1;
    repeat (2) waitCycle();
    checkOutput("busyBreakExit", 8'(busy), 8'h01);
    repeat (2) waitCycle();
    checkOutput("busyAfterBreak", 8'(busy), 8'h00);
    applyStimulus(8'h81, 1'b1, 1'b0);
    idle(5);

    // Short glitch on an idle line.
    g   = cyc;
    rxd = 1'b0;
    repeat (3) waitCycle();
    rxd = 1'b1;
    checkOutput("busyGlitch", 8'(busy), 8'h01);
    while (cyc < g + 8) waitCycle();
    checkOutput("busyGlitchEnd", 8'(busy), 8'h00);
    idle(5);

    // Consume lands on the very stop tick of the next byte.
    rx_ready = 1'b0;
    applyStimulus(8'h12, 1'b1, 1'b0);
    applyStimulus(8'h34, 1'b1, 1'b1);
    rx_ready = 1'b0;
    idle(3);
    checkOutput("stopTickData", rx_data, 8'h34);
    checkOutput("stopTickValid", 8'(rx_valid), 8'h01);
    rx_ready = 1'b1;
    idle(3);

    // Reset in the middle of bit 4 of a frame.
    rxd = 1'b0;
    repeat (CPB) waitCycle();
    rxd = 1'b1;
    repeat (4 * CPB + CPB / 2) waitCycle();
    checkOutput("busyMidFrame", 8'(busy), 8'h01);
    reset = 1'b1;
    repeat (3) waitCycle();
    reset = 1'b0;
    idle(3);
    checkOutput("busyAfterAbort", 8'(busy), 8'h00);
    applyStimulus(8'h66, 1'b1, 1'b0);
    idle(5);

    // Random frames, gaps, stop bits and consumer behaviour.
    randReady = 1'b1;
    for (int n = 0; n < 14; n++) begin
      rb  = 8'($urandom);
      rs  = ($urandom_range(0, 4) != 0);
      applyStimulus(rb, rs, 1'b0);
      gap = rs ? int'($urandom_range(0, 6)) : int'($urandom_range(4, 10));
      idle(gap);
    end
    randReady = 1'b0;
    rx_ready  = 1'b1;
    idle(5);
    checkOutput("drainedValid", 8'(rx_valid), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive end of the serial link whose transmitter already drives txd from the SoC top.
- Recovers 8N1 frames from the asynchronous rxd pin and presents each byte on a one-entry valid/ready output register for the CPU-side UART register block.
- Flags framing errors and overruns.
- Runs in the 50 MHz core clock domain (CLK_OUT2).

Parameters:
- CLK_HZ, 50000000, core clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, CLK_HZ/BAUD (integer division, 434 at defaults), clocks per bit. Derived localparam; must be >= 4.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rxd  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  received byte, valid while rx_valid=1.
- rx_valid  output  1  byte available.
- rx_ready  input  1  consumer accepts byte when rx_valid & rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: new byte arrived while the held byte was not consumed.
- busy  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Reset values:
  - Synchronizer flops = 1; state = IDLE.
  - rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0, busy = 0.
  - Bit counter, shift register and clock counter = 0.
  - Reset mid-frame aborts the frame immediately; no partial byte is delivered.
- Input sync: two-flop synchronizer on rxd gives rxd_s. All decisions use rxd_s.
- Timing: down-counter cnt (width clog2(CLKS_PER_BIT)). A "tick" is the cycle with cnt==0.
- State machine:
  - IDLE: if rxd_s==0, load cnt=CLKS_PER_BIT/2-1 and go to START.
  - START: on tick, sample rxd_s.
    - If 0: load cnt=CLKS_PER_BIT-1, bit index=0, go to DATA.
    - If 1: treat as a glitch and return to IDLE. No flags.
  - DATA: on each tick, shift rxd_s into the MSB of the shift register (LSB-first on the line), reload cnt=CLKS_PER_BIT-1 and increment the index. After the 8th sample go to STOP.
  - STOP: on tick, sample rxd_s.
    - If 1: deliver the byte (see handoff rules) and go to IDLE.
    - If 0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait until rxd_s==1, then go to IDLE. This prevents a held-low line (break) from being re-decoded as frames.
- Output handoff (same cycle as the stop tick):
  - If rx_valid==0, or rx_valid & rx_ready this cycle: load rx_data from the shift register and set rx_valid=1. A simultaneous consume and new byte gives no overrun and rx_valid stays 1.
  - If rx_valid==1 & rx_ready==0: pulse overrun. The old rx_data and rx_valid are retained; the new byte is dropped.
- Handshake rules:
  - rx_valid & rx_ready with no delivery that cycle clears rx_valid on the next edge.
  - rx_data is stable while rx_valid=1.
  - rx_ready is ignored when rx_valid=0.
- Latency: rx_valid rises exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks after the first clk edge that registers rxd low in the first synchronizer flop. The +2 is for the synchronizer and IDLE detection.
- Back-to-back frames: after delivery the block is in IDLE during the second half of the stop bit, so a start bit immediately following is accepted with no lost frame.
- frame_err and overrun are mutually exclusive per frame. Each is high for exactly one cycle.

Test Plan (CLK_HZ=1000000, BAUD=100000, so CLKS_PER_BIT=10):
- Reset, then drive frame 0x55 with rx_ready=1 -> rx_valid high one cycle, rx_data=0x55, at the latency above; frame_err=0, overrun=0.
- Send 0xA3 then 0x0F back-to-back (no idle gap) with rx_ready=0 until the second stop bit, then rx_ready=1 -> rx_data=0xA3 retained, overrun pulses once at the second stop tick, and 0xA3 is consumed once rx_ready goes high.
- Send 0x3C with the stop bit driven low, then hold rxd low for 30 clocks, then high -> frame_err pulses once, rx_valid stays 0, busy stays high until rxd returns high. A following 0x81 frame is received correctly.
- Drive a 3-clock low glitch on idle rxd -> no rx_valid, no flags, busy returns to 0 by clock 8.
- With rx_valid=1 holding 0x12, assert rx_ready on the exact stop-tick cycle of a 0x34 frame -> rx_data=0x34, rx_valid stays 1, no overrun.
- Assert reset during bit 4 of a 0xFF frame, release it, then send 0x66 -> no byte from the aborted frame, 0x66 received, all outputs were 0 during reset.
